// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master sequencer: FSM state encoding and the
// I2C controller register map that the sequencer addresses.
package apb_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int unsigned REG_ADDR_WIDTH = 8;

   // I2C controller APB register offsets
   localparam logic [REG_ADDR_WIDTH-1:0] REG_TRANSMIT   = 8'h00;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_RX_DATA    = 8'h04;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_STATUS     = 8'h08;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_SLAVE_ADDR = 8'h0C;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_COMMAND    = 8'h10;
   localparam logic [REG_ADDR_WIDTH-1:0] REG_PRESCALE   = 8'h14;

endpackage

// File: rtl/apb_master_sequencer_if.sv
// APB bus bundle between the sequencer (master) and the I2C register slave.
//   paddr_o/pwrite_o/psel_o/penable_o/pwdata_o : master -> slave
//   prdata_i/pready_i                          : slave  -> master
interface apb_master_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
) ();

   logic [ADDR_WIDTH-1:0] paddr_o;
   logic                  pwrite_o;
   logic                  psel_o;
   logic                  penable_o;
   logic [DATA_WIDTH-1:0] pwdata_o;
   logic [DATA_WIDTH-1:0] prdata_i;
   logic                  pready_i;

   modport master (
      output paddr_o, pwrite_o, psel_o, penable_o, pwdata_o,
      input  prdata_i, pready_i
   );

   modport slave (
      input  paddr_o, pwrite_o, psel_o, penable_o, pwdata_o,
      output prdata_i, pready_i
   );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter for the APB ACCESS phase.
//   pclk_i, preset_ni : clock, async active-low reset
//   clear             : restart count at zero
//   inc               : count one wait cycle (saturates at LIMIT)
//   expired_c         : count has reached LIMIT (decoded from the register)
module apb_wait_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic pclk_i,
   input  logic preset_ni,
   input  logic clear,
   input  logic inc,
   output logic expired_c
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q;

   // Wait counter; holds at LIMIT so a long stall cannot wrap
   always_ff @(posedge pclk_i or negedge preset_ni) begin
      if (!preset_ni) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != CNT_W'(LIMIT))) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign expired_c = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/apb_master_sequencer.sv
// APB initiator: converts valid/ready register requests into APB SETUP/ACCESS
// transfers and returns one registered response per request.
//   pclk_i, preset_ni        : clock, async active-low reset
//   req_valid_i/req_ready_o  : request handshake (req_ready_o is combinational
//                              from pready_i to allow back-to-back chaining)
//   req_write_i/addr/wdata   : request payload
//   rsp_valid_o/rdata/err    : one-cycle response pulse, data/err held
//   apb                      : APB master port
// Optional build macro APB_MASTER_TIMEOUT_EN adds an ACCESS wait timeout that
// aborts the transfer and reports rsp_err_o.
module apb_master_sequencer
   import apb_master_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk_i,
   input  logic                  preset_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   apb_master_sequencer_if.master apb
);

   apb_state_e            state_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic                  pwrite_q;
   logic                  psel_q;
   logic                  penable_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic                  abort_c;

`ifdef APB_MASTER_TIMEOUT_EN
   logic rsp_err_q;
   logic expired_c;

   apb_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .pclk_i    (pclk_i),
      .preset_ni (preset_ni),
      .clear     (state_q == ST_SETUP),
      .inc       ((state_q == ST_ACCESS) && !apb.pready_i),
      .expired_c (expired_c)
   );

   // Abort only when the limit is reached and the slave is still stalling
   assign abort_c   = (state_q == ST_ACCESS) && !apb.pready_i && expired_c;
   assign rsp_err_o = rsp_err_q;
`else
   logic unused_cfg;

   // TIMEOUT_CYCLES only matters in the timeout build
   assign unused_cfg = (TIMEOUT_CYCLES == 0);
   assign abort_c    = 1'b0;
   assign rsp_err_o  = 1'b0;
`endif

   // Sequencer FSM with registered APB and response outputs
   always_ff @(posedge pclk_i or negedge preset_ni) begin
      if (!preset_ni) begin
         state_q     <= ST_IDLE;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  paddr_q   <= req_addr_i;
                  pwrite_q  <= req_write_i;
                  pwdata_q  <= req_wdata_i;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  state_q   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (apb.pready_i) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= pwrite_q ? '0 : apb.prdata_i;
`ifdef APB_MASTER_TIMEOUT_EN
                  rsp_err_q   <= 1'b0;
`endif
                  penable_q   <= 1'b0;
                  // Chain straight into the next SETUP, keeping psel high
                  if (req_valid_i) begin
                     paddr_q  <= req_addr_i;
                     pwrite_q <= req_write_i;
                     pwdata_q <= req_wdata_i;
                     state_q  <= ST_SETUP;
                  end else begin
                     psel_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (abort_c) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  state_q     <= ST_IDLE;
               end
`endif
            end
            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   // Reset gating keeps ready low while the block is held in reset
   assign req_ready_o = preset_ni &&
                        ((state_q == ST_IDLE) ||
                         ((state_q == ST_ACCESS) && apb.pready_i && !abort_c));

   assign apb.paddr_o   = paddr_q;
   assign apb.pwrite_o  = pwrite_q;
   assign apb.psel_o    = psel_q;
   assign apb.penable_o = penable_q;
   assign apb.pwdata_o  = pwdata_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_sequencer.sv
// Directed testbench for apb_master_sequencer. Inputs change 1ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_apb_master_sequencer;
   import apb_master_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 8;

   logic          pclk_i = 1'b0;
   logic          preset_ni;
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_write_i;
   logic [AW-1:0] req_addr_i;
   logic [DW-1:0] req_wdata_i;
   logic          rsp_valid_o;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_err_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   apb_master_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

   apb_master_sequencer #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .pclk_i      (pclk_i),
      .preset_ni   (preset_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .apb         (apb.master)
   );

   always #5 pclk_i = ~pclk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge pclk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge pclk_i);
   endtask

   // Single transfer with a given number of ACCESS wait states
   task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int waits);
      next_cycle();
      req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_wdata_i = wd;
      apb.pready_i = 1'b0; apb.prdata_i = 8'hEE;
      sample();
      check_eq({tag, "_acc_ready"}, 32'(req_ready_o), 32'd1);
      next_cycle();
      req_valid_i = 1'b0;
      sample();
      check_eq({tag, "_setup_sel_en"}, {30'd0, apb.psel_o, apb.penable_o}, 32'b10);
      check_eq({tag, "_setup_addr"}, 32'(apb.paddr_o), 32'(addr));
      check_eq({tag, "_setup_write"}, 32'(apb.pwrite_o), 32'(wr));
      if (wr) check_eq({tag, "_setup_wdata"}, 32'(apb.pwdata_o), 32'(wd));
      for (int w = 0; w < waits; w++) begin
         next_cycle();
         sample();
         check_eq({tag, "_wait_ctl"}, {28'd0, apb.psel_o, apb.penable_o, req_ready_o, rsp_valid_o},
                  32'b1100);
         check_eq({tag, "_wait_addr"}, {23'd0, apb.pwrite_o, apb.paddr_o}, {23'd0, wr, addr});
      end
      next_cycle();
      apb.pready_i = 1'b1; apb.prdata_i = rd;
      sample();
      check_eq({tag, "_access_ctl"}, {28'd0, apb.psel_o, apb.penable_o, req_ready_o, rsp_valid_o},
               32'b1110);
      check_eq({tag, "_access_addr"}, 32'(apb.paddr_o), 32'(addr));
      next_cycle();
      apb.pready_i = 1'b0; apb.prdata_i = 8'h3C;
      sample();
      check_eq({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
      check_eq({tag, "_rsp_rdata"}, 32'(rsp_rdata_o), wr ? 32'd0 : 32'(rd));
      check_eq({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
      check_eq({tag, "_idle_sel_en"}, {30'd0, apb.psel_o, apb.penable_o}, 32'b00);
      next_cycle();
      sample();
      check_eq({tag, "_rsp_pulse"}, 32'(rsp_valid_o), 32'd0);
      check_eq({tag, "_rsp_hold"}, 32'(rsp_rdata_o), wr ? 32'd0 : 32'(rd));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      preset_ni    = 1'b1;
      req_valid_i  = 1'b0;
      req_write_i  = 1'b0;
      req_addr_i   = '0;
      req_wdata_i  = '0;
      apb.prdata_i = '0;
      apb.pready_i = 1'b0;
      #2 preset_ni = 1'b0;

      // Reset state
      sample();
      check_eq("rst_ready", 32'(req_ready_o), 32'd0);
      check_eq("rst_apb", {13'd0, apb.psel_o, apb.penable_o, apb.pwrite_o, apb.paddr_o, apb.pwdata_o},
               32'd0);
      check_eq("rst_rsp", {22'd0, rsp_valid_o, rsp_err_o, rsp_rdata_o}, 32'd0);
      next_cycle();
      preset_ni = 1'b1;
      sample();
      check_eq("rel_ready", 32'(req_ready_o), 32'd1);

      xfer("wr_prescale", 1'b1, REG_PRESCALE, 8'h1F, 8'h00, 0);
      xfer("rd_status", 1'b0, REG_STATUS, 8'h00, 8'hA5, 0);

      // Back-to-back write then read with req_valid held
      next_cycle();
      req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = REG_TRANSMIT; req_wdata_i = 8'h55;
      apb.pready_i = 1'b1;
      next_cycle();
      req_write_i = 1'b0; req_addr_i = REG_RX_DATA; req_wdata_i = 8'h00;
      sample();
      check_eq("b2b_setup1", {28'd0, apb.psel_o, apb.penable_o, apb.pwrite_o, req_ready_o}, 32'b1010);
      check_eq("b2b_setup1_data", {apb.paddr_o, apb.pwdata_o}, {8'h00, 8'h55});
      next_cycle();
      sample();
      check_eq("b2b_access1", {28'd0, apb.psel_o, apb.penable_o, req_ready_o, rsp_valid_o}, 32'b1110);
      next_cycle();
      req_valid_i = 1'b0; apb.prdata_i = 8'h6B;
      sample();
      check_eq("b2b_setup2", {29'd0, apb.psel_o, apb.penable_o, apb.pwrite_o}, 32'b100);
      check_eq("b2b_setup2_addr", 32'(apb.paddr_o), 32'(REG_RX_DATA));
      check_eq("b2b_rsp1", {23'd0, rsp_valid_o, rsp_rdata_o}, {23'd0, 1'b1, 8'h00});
      next_cycle();
      sample();
      check_eq("b2b_access2", {29'd0, apb.psel_o, apb.penable_o, rsp_valid_o}, 32'b110);
      next_cycle();
      apb.pready_i = 1'b0;
      sample();
      check_eq("b2b_rsp2", {23'd0, rsp_valid_o, rsp_rdata_o}, {23'd0, 1'b1, 8'h6B});
      check_eq("b2b_end_sel", {30'd0, apb.psel_o, apb.penable_o}, 32'b00);

      xfer("rd_wait3", 1'b0, REG_COMMAND, 8'h00, 8'h80, 3);

`ifdef APB_MASTER_TIMEOUT_EN
      // Stalled slave: 16 counted waits, abort on the next stalled cycle
      next_cycle();
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = REG_STATUS;
      apb.pready_i = 1'b0; apb.prdata_i = 8'h5A;
      next_cycle();
      req_valid_i = 1'b0;
      for (int i = 0; i < 17; i++) begin
         next_cycle();
         sample();
         check_eq("to_wait", {28'd0, apb.psel_o, apb.penable_o, req_ready_o, rsp_valid_o}, 32'b1100);
      end
      next_cycle();
      sample();
      check_eq("to_rsp", {22'd0, rsp_valid_o, rsp_err_o, rsp_rdata_o}, {22'd0, 2'b11, 8'h00});
      check_eq("to_sel_en", {30'd0, apb.psel_o, apb.penable_o}, 32'b00);
      next_cycle();
      sample();
      check_eq("to_err_hold", {30'd0, rsp_valid_o, rsp_err_o}, 32'b01);
      xfer("to_limit_ok", 1'b0, REG_STATUS, 8'h00, 8'hC3, 16);
`endif

      // Reset asserted in the middle of ACCESS
      next_cycle();
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = REG_STATUS; req_wdata_i = 8'h99;
      apb.pready_i = 1'b0;
      next_cycle();
      req_valid_i = 1'b0;
      next_cycle();
      sample();
      check_eq("mid_access", {30'd0, apb.psel_o, apb.penable_o}, 32'b11);
      #2 preset_ni = 1'b0;
      #1;
      check_eq("mid_rst_ready", 32'(req_ready_o), 32'd0);
      check_eq("mid_rst_apb", {13'd0, apb.psel_o, apb.penable_o, apb.pwrite_o, apb.paddr_o, apb.pwdata_o},
               32'd0);
      check_eq("mid_rst_rsp", {22'd0, rsp_valid_o, rsp_err_o, rsp_rdata_o}, 32'd0);
      next_cycle();
      apb.pready_i = 1'b1;
      next_cycle();
      preset_ni = 1'b1;
      sample();
      check_eq("post_rst_ready", 32'(req_ready_o), 32'd1);
      check_eq("post_rst_sel", 32'(apb.psel_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         sample();
         check_eq("post_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master_sequencer.md
# apb_master_sequencer

Single-clock APB initiator that turns a simple valid/ready request interface into APB SETUP/ACCESS transfers toward the I2C controller's APB slave register map. Firmware-side or test-side logic issues register reads and writes, such as prescale, slave address, command, transmit data, RX-FIFO pops and status polls. The block returns one response per request, carrying read data and an optional timeout error. It sits between a CPU/sequencer port and the I2C block's APB slave port, in the `pclk_i` domain.

## Interface
- `DATA_WIDTH`, 8: APB data width.
- `ADDR_WIDTH`, 8: APB address width.
- `TIMEOUT_CYCLES`, 16: max ACCESS cycles with `pready_i` low before abort (used only with timeout feature); must be ≥1.

- `pclk_i`  in  1  APB clock; single clock for the block.
- `preset_ni`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted this cycle when high with `req_valid_i`.
- `req_write_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  ADDR_WIDTH  register address.
- `req_wdata_i`  in  DATA_WIDTH  write data.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_rdata_o`  out  DATA_WIDTH  read data; 0 for writes and aborted transfers.
- `rsp_err_o`  out  1  transfer aborted by timeout; qualified by `rsp_valid_o`.
- `paddr_o`  out  ADDR_WIDTH  APB address.
- `pwrite_o`  out  1  APB direction.
- `psel_o`  out  1  APB select.
- `penable_o`  out  1  APB enable.
- `pwdata_o`  out  DATA_WIDTH  APB write data.
- `prdata_i`  in  DATA_WIDTH  APB read data.
- `pready_i`  in  1  APB ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i`, register addr/write/wdata onto the APB outputs and go to SETUP.
- SETUP:
  - `psel_o`=1, `penable_o`=0.
  - Always goes to ACCESS next cycle.
- ACCESS:
  - `psel_o`=1, `penable_o`=1.
  - On `pready_i`=1, the transfer completes:
    - Read: capture `prdata_i` into `rsp_rdata_o`.
    - Write: load 0 into `rsp_rdata_o`.
  - After completion, if `req_valid_i` is high in the same cycle, go directly to SETUP with the new request. `psel_o` stays high and `penable_o` drops. Otherwise go to IDLE with `psel_o`=0.
- `req_ready_o` = (state==IDLE) | (state==ACCESS & `pready_i` & ~abort). It has a combinational path from `pready_i`.
- APB address, control and data outputs are stable from SETUP through the end of ACCESS. `pwdata_o` is driven for reads too (holds the last value, don't-care).
- No response backpressure. The consumer must accept every `rsp_valid_o` pulse.
- Reset mid-transfer:
  - Every output goes to 0 asynchronously and the FSM goes to IDLE.
  - The in-flight request is dropped and no response is issued.

## Timing
- Reset values: all outputs 0 (`req_ready_o` becomes 1 on the first cycle after reset release, in IDLE).
- Minimum transfer: 2 APB cycles (SETUP + ACCESS), given that the I2C slave drives `pready` = `psel`.
- Latency:
  - Request acceptance at edge N, SETUP in cycle N+1, ACCESS in cycle N+2.
  - `rsp_valid_o` is high in cycle N+3 with zero wait states.
  - Each wait state adds one cycle.
- `rsp_valid_o`, `rsp_rdata_o` and `rsp_err_o` are registered. `rsp_rdata_o` and `rsp_err_o` hold until the next response.
- Back-to-back throughput: one transfer per 2 cycles.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A wait counter, clear in SETUP, increments each ACCESS cycle with `pready_i`=0.
  - When the count reaches `TIMEOUT_CYCLES` and `pready_i` is still 0, the transfer aborts:
    - `psel_o` and `penable_o` go to 0 and the FSM goes to IDLE. No back-to-back chaining on abort.
    - Next cycle: `rsp_valid_o`=1, `rsp_err_o`=1, `rsp_rdata_o`=0.
  - If `pready_i`=1 in the cycle the limit is reached, the transfer completes normally.
- Undefined: no counter. ACCESS waits indefinitely and `rsp_err_o` is tied 0.

## Structure
- Shared package `apb_master_pkg`:
  - FSM state typedef (IDLE/SETUP/ACCESS).
  - I2C register address constants: TRANSMIT 0x00, RX_DATA 0x04, STATUS 0x08, SLAVE_ADDR 0x0C, COMMAND 0x10, PRESCALE 0x14.
- Sub-module `apb_wait_timer`: saturating wait counter with clear/inc/expired, instantiated only under `APB_MASTER_TIMEOUT_EN`.

## Test plan
- Write 0x1F to 0x14 with `pready_i`=1:
  - SETUP then ACCESS, `paddr_o`=0x14, `pwdata_o`=0x1F, `pwrite_o`=1.
  - `rsp_valid_o` 3 cycles after accept, `rsp_rdata_o`=0x00, `rsp_err_o`=0.
- Read 0x08 with slave `prdata_i`=0xA5 in ACCESS -> `rsp_rdata_o`=0xA5, one `rsp_valid_o` pulse.
- Write 0x55 to 0x00 followed immediately by read 0x04 (`req_valid_i` held):
  - `psel_o` stays 1 across both transfers and `penable_o` pattern is 0,1,0,1.
  - Two responses spaced 2 cycles apart.
- Read 0x10 with `pready_i` low for 3 ACCESS cycles, then high with `prdata_i`=0x80 -> response after 3 extra cycles, data 0x80, all APB outputs stable throughout.
- With `APB_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `pready_i` held 0 -> abort after 16 ACCESS cycles, `rsp_err_o`=1, `rsp_rdata_o`=0, `psel_o`=0.
- Assert `preset_ni` low mid-ACCESS -> all outputs 0 immediately, no response after release, `req_ready_o`=1 on the first cycle out of reset.
